// File: rtl/strand_frame_loader.sv
// Byte-stream front end for the WS2801/WS2811 strand driver: packs bytes into 24-bit pixels, fills the pixel RAM, launches frames.
// Optional macro HYDRA_DOUBLE_BUFFER_EN ping-pongs two RAM banks so a new frame can load while the previous one transmits.
`timescale 1ns/1ps
module strand_frame_loader #(
    parameter int MEM_DATA_WIDTH     = 24,
    parameter int STRAND_PARAM_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [STRAND_PARAM_WIDTH-1:0] strand_length,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    input  logic                          in_sof,
    output logic                          in_ready,
    output logic                          mem_wr_en,
    output logic [STRAND_PARAM_WIDTH-1:0] mem_wr_addr,
    output logic [MEM_DATA_WIDTH-1:0]     mem_wr_data,
    output logic                          mem_wr_bank,
    output logic                          rd_bank,
    input  logic                          driver_busy,
    output logic                          start_frame,
    output logic                          err_short,
    output logic                          err_long
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_READY  = 3'd2,
        S_LAUNCH = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t                        state_reg, state_next;
    logic [STRAND_PARAM_WIDTH-1:0] len_reg, len_next;
    logic [STRAND_PARAM_WIDTH-1:0] idx_reg, idx_next;
    logic [1:0]                    phase_reg, phase_next;
    logic [7:0]                    byte0_reg, byte0_next;
    logic [7:0]                    byte1_reg, byte1_next;
    logic                          in_ready_reg, in_ready_next;
    logic                          wr_en_reg, wr_en_next;
    logic [STRAND_PARAM_WIDTH-1:0] wr_addr_reg, wr_addr_next;
    logic [MEM_DATA_WIDTH-1:0]     wr_data_reg, wr_data_next;
    logic                          start_reg, start_next;
    logic                          err_short_reg, err_short_next;
    logic                          err_long_reg, err_long_next;

    logic accept;
    logic launch;
    logic last_pixel;

    assign accept     = in_valid & in_ready_reg;
    assign launch     = (state_reg == S_READY) & ~driver_busy;
    assign last_pixel = (idx_reg == len_reg - STRAND_PARAM_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            idx_reg       <= '0;
            phase_reg     <= '0;
            byte0_reg     <= '0;
            byte1_reg     <= '0;
            in_ready_reg  <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            start_reg     <= 1'b0;
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            idx_reg       <= idx_next;
            phase_reg     <= phase_next;
            byte0_reg     <= byte0_next;
            byte1_reg     <= byte1_next;
            in_ready_reg  <= in_ready_next;
            wr_en_reg     <= wr_en_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
            start_reg     <= start_next;
            err_short_reg <= err_short_next;
            err_long_reg  <= err_long_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        idx_next       = idx_reg;
        phase_next     = phase_reg;
        byte0_next     = byte0_reg;
        byte1_next     = byte1_reg;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        start_next     = 1'b0;
        err_short_next = 1'b0;
        err_long_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (!in_sof) begin
                        err_long_next = 1'b1;
                    end else if (strand_length != '0) begin
                        len_next   = strand_length;
                        idx_next   = '0;
                        phase_next = 2'd1;
                        byte0_next = in_data;
                        state_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    if (in_sof) begin
                        // A SOF always wins over the frame in progress, even on its final byte.
                        err_short_next = 1'b1;
                        if (strand_length != '0) begin
                            len_next   = strand_length;
                            idx_next   = '0;
                            phase_next = 2'd1;
                            byte0_next = in_data;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        case (phase_reg)
                            2'd0: begin
                                byte0_next = in_data;
                                phase_next = 2'd1;
                            end
                            2'd1: begin
                                byte1_next = in_data;
                                phase_next = 2'd2;
                            end
                            default: begin
                                wr_en_next   = 1'b1;
                                wr_addr_next = idx_reg;
                                wr_data_next = MEM_DATA_WIDTH'({in_data, byte1_reg, byte0_reg});
                                phase_next   = 2'd0;
                                if (last_pixel) begin
                                    state_next = S_READY;
                                end else begin
                                    idx_next = idx_reg + STRAND_PARAM_WIDTH'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            S_READY: begin
                if (launch) begin
                    start_next = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // The driver acknowledges start_frame by raising busy a cycle later.
                if (driver_busy) begin
`ifdef HYDRA_DOUBLE_BUFFER_EN
                    state_next = S_IDLE;
`else
                    state_next = S_DRAIN;
`endif
                end
            end
            S_DRAIN: begin
                if (!driver_busy) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        in_ready_next = (state_next == S_IDLE) || (state_next == S_FILL);
    end

`ifdef HYDRA_DOUBLE_BUFFER_EN
    logic wr_bank_reg, wr_bank_next;
    logic rd_bank_reg, rd_bank_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
        end else begin
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
        end
    end

    // Hand the freshly written bank to the driver and start filling the other one.
    always_comb begin
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        if (launch) begin
            rd_bank_next = wr_bank_reg;
            wr_bank_next = ~wr_bank_reg;
        end
    end

    assign mem_wr_bank = wr_bank_reg;
    assign rd_bank     = rd_bank_reg;
`else
    assign mem_wr_bank = 1'b0;
    assign rd_bank     = 1'b0;
`endif

    assign in_ready    = in_ready_reg;
    assign mem_wr_en   = wr_en_reg;
    assign mem_wr_addr = wr_addr_reg;
    assign mem_wr_data = wr_data_reg;
    assign start_frame = start_reg;
    assign err_short   = err_short_reg;
    assign err_long    = err_long_reg;

endmodule

// File: tb/tb_strand_frame_loader.sv
// Self-checking bench for strand_frame_loader: directed frames with literal expectations plus a randomized stream
// compared every cycle against a byte-queue reference model. Honors HYDRA_DOUBLE_BUFFER_EN like the design.
`timescale 1ns/1ps
module tb_strand_frame_loader;

`ifdef HYDRA_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] strand_length = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        driver_busy = 1'b0;
    logic        in_ready, mem_wr_en, mem_wr_bank, rd_bank, start_frame, err_short, err_long;
    logic [15:0] mem_wr_addr;
    logic [23:0] mem_wr_data;

    strand_frame_loader dut (
        .clk(clk), .rst_n(rst_n), .strand_length(strand_length),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_bank(mem_wr_bank), .rd_bank(rd_bank), .driver_busy(driver_busy),
        .start_frame(start_frame), .err_short(err_short), .err_long(err_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: frames as byte queues and pixel counts ----------------
    typedef enum {M_IDLE, M_LOAD, M_WAIT_DRV, M_WAIT_BUSY, M_WAIT_DONE} mode_t;
    mode_t       mode = M_IDLE;
    logic [7:0]  pend[$];
    int          npix = 0;
    int          frame_len = 0;
    logic        e_ready = 0, e_wr = 0, e_wbank = 0, e_rbank = 0, e_start = 0, e_short = 0, e_long = 0;
    logic [15:0] e_addr = '0;
    logic [23:0] e_data = '0;

    task automatic model_reset();
        mode = M_IDLE; pend.delete(); npix = 0; frame_len = 0;
        e_ready = 0; e_wr = 0; e_wbank = 0; e_rbank = 0; e_start = 0; e_short = 0; e_long = 0;
        e_addr = '0; e_data = '0;
    endtask

    task automatic begin_frame();
        frame_len = int'(strand_length);
        pend.delete();
        pend.push_back(in_data);
        npix = 0;
        mode = M_LOAD;
    endtask

    task automatic model_step();
        bit acc;
        acc = in_valid && e_ready;
        e_wr = 0; e_start = 0; e_short = 0; e_long = 0;
        case (mode)
            M_IDLE: if (acc) begin
                if (!in_sof) e_long = 1;
                else if (strand_length != 0) begin_frame();
            end
            M_LOAD: if (acc) begin
                if (in_sof) begin
                    e_short = 1;
                    if (strand_length != 0) begin_frame();
                    else begin pend.delete(); mode = M_IDLE; end
                end else begin
                    pend.push_back(in_data);
                    if (pend.size() == 3) begin
                        e_wr = 1;
                        e_addr = 16'(npix);
                        e_data = {pend[2], pend[1], pend[0]};
                        pend.delete();
                        npix++;
                        if (npix == frame_len) mode = M_WAIT_DRV;
                    end
                end
            end
            M_WAIT_DRV: if (!driver_busy) begin
                e_start = 1;
                e_rbank = e_wbank;
                if (DB) e_wbank = ~e_wbank;
                mode = M_WAIT_BUSY;
            end
            M_WAIT_BUSY: if (driver_busy) mode = DB ? M_IDLE : M_WAIT_DONE;
            M_WAIT_DONE: if (!driver_busy) mode = M_IDLE;
            default: mode = M_IDLE;
        endcase
        e_ready = (mode == M_IDLE) || (mode == M_LOAD);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, e_ready);
            chk("mem_wr_en", mem_wr_en, e_wr);
            chk("mem_wr_addr", mem_wr_addr, e_addr);
            chk("mem_wr_data", mem_wr_data, e_data);
            chk("mem_wr_bank", mem_wr_bank, e_wbank);
            chk("rd_bank", rd_bank, e_rbank);
            chk("start_frame", start_frame, e_start);
            chk("err_short", err_short, e_short);
            chk("err_long", err_long, e_long);
        end
    end

    // ---------------- output monitor ----------------
    logic [40:0] wr_log[$];
    int n_start = 0, n_short = 0, n_long = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (mem_wr_en) begin
                wr_log.push_back({mem_wr_bank, mem_wr_addr, mem_wr_data});
                $display("write bank %0d addr %0d data %06h (cycle %0d)", mem_wr_bank, mem_wr_addr, mem_wr_data, cyc);
            end
            if (start_frame) n_start++;
            if (err_short) n_short++;
            if (err_long) n_long++;
        end
    end

    // ---------------- strand driver emulation ----------------
    int   tx_len = 4;
    int   busy_cnt = 0;
    bit   rand_busy = 0;
    logic ext_busy = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) busy_cnt = 0;
            else if (start_frame) busy_cnt = tx_len;
            else if (busy_cnt > 0) busy_cnt--;
            ext_busy = rand_busy && ($urandom_range(0, 7) == 0);
            driver_busy = (busy_cnt > 0) || ext_busy;
        end
    end

    // ---------------- stimulus helpers ----------------
    int xfer_cyc = 0;
    int start_cyc = 0;

    task automatic send_byte(input logic [7:0] d, input bit sof);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_sof = sof;
        while (in_ready !== 1'b1 && t < 5000) begin @(negedge clk); t++; end
        if (t >= 5000) chk("send_timeout", 0, 1);
        xfer_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0; in_sof = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic wait_start(input int limit);
        int t = 0;
        do begin @(negedge clk); t++; end while (start_frame !== 1'b1 && t < limit);
        chk("start_seen", start_frame, 1);
        start_cyc = cyc;
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        do begin @(negedge clk); t++; end while (!(in_ready === 1'b1 && driver_busy === 1'b0) && t < limit);
        chk("idle_reached", (in_ready === 1'b1 && driver_busy === 1'b0), 1);
    endtask

    task automatic send_pixels(input logic [15:0] len, input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) begin
            if (i == 0) strand_length = len;
            send_byte(b[i], i == 0);
            strand_length = 16'($urandom);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int s0, w0, sh0, l0, t1, viol, ticks;
        logic [7:0] bytes[$];

        repeat (3) @(negedge clk);
        chk("reset_outputs", {in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_bank, rd_bank,
                              start_frame, err_short, err_long}, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);

        // basic frame
        $display("test basic frame");
        tx_len = 6; w0 = wr_log.size();
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_pixels(16'd2, bytes);
        wait_start(50);
        chk("basic_latency", start_cyc - xfer_cyc, 2);
        chk("basic_rd_bank", rd_bank, 0);
        chk("basic_nwrites", wr_log.size() - w0, 2);
        chk("basic_wr0", wr_log[w0], {1'b0, 16'd0, 24'h332211});
        chk("basic_wr1", wr_log[w0+1], {1'b0, 16'd1, 24'h665544});
`ifndef HYDRA_DOUBLE_BUFFER_EN
        viol = 0; ticks = 0;
        @(negedge clk);
        while (driver_busy === 1'b1 && ticks < 100) begin
            if (in_ready !== 1'b0) viol++;
            @(negedge clk); ticks++;
        end
        chk("ready_low_during_tx", viol, 0);
        chk("tx_observed", ticks > 0, 1);
`endif
        wait_idle(100);

        // short frame, then a 1-pixel frame
        $display("test short frame");
        s0 = n_start; sh0 = n_short; w0 = wr_log.size();
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_pixels(16'd4, bytes);
        bytes = '{8'hA1, 8'hB2, 8'hC3};
        send_pixels(16'd1, bytes);
        wait_start(50);
        wait_idle(100);
        chk("short_err_count", n_short - sh0, 1);
        chk("short_start_count", n_start - s0, 1);
        chk("short_nwrites", wr_log.size() - w0, 2);
        chk("short_last_wr", wr_log[wr_log.size()-1], {DB, 16'd0, 24'hC3B2A1});

        // excess bytes
        $display("test excess bytes");
        l0 = n_long; w0 = wr_log.size();
        for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b0);
        repeat (3) @(negedge clk);
        chk("excess_err_long", n_long - l0, 3);
        chk("excess_nwrites", wr_log.size() - w0, 0);

`ifdef HYDRA_DOUBLE_BUFFER_EN
        $display("test double buffer");
        tx_len = 1000;
        bytes = '{8'h10, 8'h20, 8'h30};
        send_pixels(16'd1, bytes);
        wait_start(50);
        t1 = start_cyc;
        chk("db_first_rd_bank", rd_bank, 0);
        bytes = '{8'h40, 8'h50, 8'h60};
        send_pixels(16'd1, bytes);
        chk("db_second_wr", wr_log[wr_log.size()-1], {1'b1, 16'd0, 24'h605040});
        chk("db_loaded_while_busy", driver_busy, 1);
        wait_start(2000);
        chk("db_holdoff", (start_cyc - t1) >= 1000, 1);
        chk("db_second_rd_bank", rd_bank, 1);
        tx_len = 4;
        wait_idle(100);
`endif

        // reset mid-frame
        $display("test reset mid-frame");
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_pixels(16'd2, bytes);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_bank, rd_bank,
                                       start_frame, err_short, err_long}, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        bytes = '{8'h5A, 8'h6B, 8'h7C};
        send_pixels(16'd1, bytes);
        wait_start(50);
        chk("post_reset_wr", wr_log[wr_log.size()-1], {1'b0, 16'd0, 24'h7C6B5A});
        chk("post_reset_rd_bank", rd_bank, 0);
        wait_idle(100);

        // randomized stream
        $display("test random stream");
        rand_busy = 1;
        for (int f = 0; f < 40; f++) begin
            int len, nb, kind;
            len = $urandom_range(0, 5);
            kind = $urandom_range(0, 9);
            tx_len = $urandom_range(1, 12);
            nb = (len == 0) ? 1 : 3 * len;
            if (kind == 0 && nb > 1) nb = $urandom_range(1, nb - 1);
            else if (kind == 1) nb = nb - 1;
            else if (kind == 2) nb += $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                if (b == 0) strand_length = 16'(len);
                send_byte(8'($urandom), b == 0);
                strand_length = 16'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            $display("random frame %0d: len %0d bytes %0d", f, len, nb);
        end
        rand_busy = 0;
        repeat (20) @(negedge clk);
        chk("random_wrote_something", wr_log.size() > 10, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/strand_frame_loader.md
# strand_frame_loader

Upstream feeder for the WS2801/WS2811 strand driver. It accepts a byte stream over a valid/ready handshake, packs every three bytes into one 24-bit pixel word, and writes the words into the pixel RAM. Once a full frame of `strand_length` pixels is written, it pulses `start_frame` to the driver when the driver is idle. Optionally, it double-buffers the RAM so the next frame can load while the current one is transmitted.

## Interface
- `MEM_DATA_WIDTH`, 24, pixel word width (fixed at 3 bytes).
- `STRAND_PARAM_WIDTH`, 16, width of pixel index and length.
- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  reset; asynchronous, active-low.
- `strand_length`  in  16  pixels per frame; sampled only on a SOF byte.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  byte valid.
- `in_sof`  in  1  qualifies `in_data` as the first byte of a frame; meaningful only with `in_valid`.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_wr_en`  out  1  pixel RAM write strobe.
- `mem_wr_addr`  out  16  pixel index written.
- `mem_wr_data`  out  24  packed pixel word.
- `mem_wr_bank`  out  1  RAM bank being written.
- `rd_bank`  out  1  RAM bank the driver reads.
- `driver_busy`  in  1  busy flag from the strand driver.
- `start_frame`  out  1  one-cycle launch pulse to the driver.
- `err_short`  out  1  one-cycle pulse: SOF arrived before the frame was complete.
- `err_long`  out  1  one-cycle pulse per excess byte discarded.

## Operation
- **Handshake:** a byte transfers on a rising edge where `in_valid & in_ready` is high.
- **Packing:** byte 0 goes to `[7:0]`, byte 1 to `[15:8]`, byte 2 to `[23:16]`. The driver shifts bit 0 first.
- **States** (3-bit register):
  - **S_IDLE**
    - `in_ready`=1.
    - A SOF byte latches `strand_length` into `len_q`, clears the pixel index and byte phase, stores byte 0, and moves to S_FILL.
    - If `len_q` would be 0, the SOF byte is instead discarded and the state stays S_IDLE.
    - A non-SOF byte is discarded and pulses `err_long`.
  - **S_FILL**
    - `in_ready`=1.
    - The byte phase counts 0→1→2→0.
    - On each phase-2 byte, the block writes the word at the current index, then increments the index.
    - After writing index `len_q-1`, the state moves to S_READY.
    - A SOF byte pulses `err_short` and restarts the frame in the same bank at index 0. That byte becomes byte 0 and `strand_length` is re-latched.
  - **S_READY**
    - `in_ready`=0.
    - When `driver_busy`=0, the block asserts `start_frame` for one cycle, sets `rd_bank` to `mem_wr_bank`, toggles `mem_wr_bank`, and moves to S_LAUNCH.
  - **S_LAUNCH**
    - `in_ready`=0.
    - Waits for `driver_busy`=1, because the driver raises busy one cycle after sampling `start_frame`.
    - Then moves to S_IDLE (double-buffer build) or S_DRAIN (single-buffer build).
  - **S_DRAIN**
    - `in_ready`=0.
    - Waits for `driver_busy`=0, then moves to S_IDLE.
- The index does not wrap: its maximum is `len_q-1`, and length is compared as unsigned 16-bit.
- **Reset** (any time, including mid-frame):
  - All outputs go to 0.
  - State is S_IDLE; `mem_wr_bank`=0; `rd_bank`=0.
  - The partial frame is abandoned.

## Timing
- All outputs are registered.
- `mem_wr_en` is high on the cycle after the phase-2 byte transfers.
- The S_FILL→S_READY transition takes effect on the same edge as that write.
- `start_frame` is high on the cycle after the first S_READY edge that sees `driver_busy`=0. Minimum latency from the last byte to `start_frame` is 2 cycles.
- `start_frame` is never asserted twice without an intervening `driver_busy` rising edge.
- When SOF and the final byte coincide, SOF wins: the old frame is aborted and `err_short` pulses.

## Configuration
- `HYDRA_DOUBLE_BUFFER_EN` defined:
  - Two banks.
  - S_LAUNCH goes to S_IDLE, so the next frame loads into the other bank while the driver transmits.
  - S_READY stalls only if that frame completes while the driver is still busy.
- Undefined:
  - `mem_wr_bank` and `rd_bank` are tied to 0.
  - S_LAUNCH goes to S_DRAIN, so `in_ready` stays low for the whole transmission.

## Test plan
- **Basic frame:** `strand_length`=2, send SOF+bytes 11,22,33,44,55,66 with the driver idle.
  - Writes: addr0 = 0x332211, then addr1 = 0x665544, both in bank 0.
  - `start_frame` pulses once, 2 cycles after byte 66; `rd_bank`=0.
- **Short frame:** `strand_length`=4, send 5 bytes, then a new SOF.
  - `err_short` pulses once; the next write lands at addr0.
  - No `start_frame` from the aborted frame.
- **Excess bytes:** after a 1-pixel frame launches, send 3 non-SOF bytes.
  - `err_long` pulses 3 times; no writes.
- **Double buffer:** hold `driver_busy`=1 for 1000 cycles after the first launch, then load a second frame.
  - Second frame is written to bank 1.
  - `start_frame` is held off until `driver_busy` falls, after which `rd_bank`=1.
- **Single buffer (macro off):** `in_ready`=0 from `start_frame` until `driver_busy` falls.
- **Reset mid-frame:** drive `rst_n` low after 4 bytes.
  - All outputs go to 0 asynchronously.
  - After release, a full frame loads to addr0 in bank 0.
